// File: rtl/sw_term_cfg_matrix_pkg.sv
// Shared definitions for the switch-terminal config matrix: group modes,
// config chain length and the PRBS generator polynomial.
package sw_term_cfg_matrix_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'b00,
    MODE_REG    = 2'b01,
    MODE_TIE    = 2'b10,
    MODE_PRBS   = 2'b11
  } mode_e;

  localparam int unsigned CFG_BITS     = 8;
  localparam int unsigned LFSR_W       = 16;
  // Taps 16,14,13,11 map onto state bits 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sw_term_group.sv
// One wire group: bit-reversed return path with bypass, registered,
// tied-off and PRBS output modes.
module sw_term_group
  import sw_term_cfg_matrix_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [1:0]    mode_i,
  input  logic [W-1:0]  in_i,
  input  logic [15:0]   lfsr_i,
  output logic [W-1:0]  out_o
);

  logic [W-1:0] rev;
  logic [W-1:0] prbs;
  logic [W-1:0] pipe_d;
  logic [W-1:0] pipe_q;

  always_comb begin
    rev  = '0;
    prbs = '0;
    for (int unsigned i = 0; i < W; i++) begin
      rev[i]  = in_i[W-1-i];
      prbs[i] = lfsr_i[i % LFSR_W];
    end
  end

  // Pipe captures every cycle so a switch into REG shows no bubble.
  assign pipe_d = rev;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) pipe_q <= '0;
    else         pipe_q <= pipe_d;
  end

  always_comb begin
    out_o = '0;
    case (mode_e'(mode_i))
      MODE_BYPASS: out_o = rev;
      MODE_REG:    out_o = pipe_q;
      MODE_TIE:    out_o = '0;
      MODE_PRBS:   out_o = prbs;
      default:     out_o = '0;
    endcase
  end

endmodule

// File: rtl/sw_term_cfg_matrix.sv
// Switch-terminal return matrix with a serial shadow/active mode register
// and a shared PRBS source for the four wire groups.
module sw_term_cfg_matrix
  import sw_term_cfg_matrix_pkg::*;
#(
  parameter int unsigned N1W       = 4,
  parameter int unsigned N2W       = 8,
  parameter int unsigned N4W       = 16,
  parameter logic [15:0] LFSR_SEED = DEFAULT_SEED
) (
  input  logic           UserCLK,
  input  logic           UserRST_N,
  input  logic [N1W-1:0] S1END,
  input  logic [N2W-1:0] S2MID,
  input  logic [N2W-1:0] S2END,
  input  logic [N4W-1:0] S4END,
  output logic [N1W-1:0] N1BEG,
  output logic [N2W-1:0] N2BEG,
  output logic [N2W-1:0] N2BEGb,
  output logic [N4W-1:0] N4BEG,
  input  logic           cfg_shift,
  input  logic           cfg_in,
  input  logic           cfg_update,
  output logic           cfg_out
);

  if (N4W < 1 || N4W > 16) begin : g_bad_n4w
    $error("sw_term_cfg_matrix: N4W must be in 1..16");
  end
  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("sw_term_cfg_matrix: LFSR_SEED must be nonzero");
  end

  logic [CFG_BITS-1:0] shadow_d, shadow_q;
  logic [CFG_BITS-1:0] active_d, active_q;
  logic [15:0]         lfsr_d, lfsr_q;
  logic [CFG_BITS-1:0] mode_eff;

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    // Update samples the pre-shift shadow even when both strobes coincide.
    if (cfg_update) active_d = shadow_q;
    if (cfg_shift)  shadow_d = {cfg_in, shadow_q[CFG_BITS-1:1]};
    lfsr_d = lfsr_step(lfsr_q);
  end

  always_ff @(posedge UserCLK) begin
    if (!UserRST_N) begin
      shadow_q <= '0;
      active_q <= '0;
      lfsr_q   <= LFSR_SEED;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      lfsr_q   <= lfsr_d;
    end
  end

  assign cfg_out = shadow_q[0];

  // Holding reset forces the legacy reversal even before the first edge.
  assign mode_eff = UserRST_N ? active_q : '0;

  sw_term_group #(.W(N1W)) u_g0 (
    .clk_i(UserCLK), .rst_ni(UserRST_N), .mode_i(mode_eff[1:0]),
    .in_i(S1END), .lfsr_i(lfsr_q), .out_o(N1BEG)
  );

  sw_term_group #(.W(N2W)) u_g1 (
    .clk_i(UserCLK), .rst_ni(UserRST_N), .mode_i(mode_eff[3:2]),
    .in_i(S2MID), .lfsr_i(lfsr_q), .out_o(N2BEG)
  );

  sw_term_group #(.W(N2W)) u_g2 (
    .clk_i(UserCLK), .rst_ni(UserRST_N), .mode_i(mode_eff[5:4]),
    .in_i(S2END), .lfsr_i(lfsr_q), .out_o(N2BEGb)
  );

  sw_term_group #(.W(N4W)) u_g3 (
    .clk_i(UserCLK), .rst_ni(UserRST_N), .mode_i(mode_eff[7:6]),
    .in_i(S4END), .lfsr_i(lfsr_q), .out_o(N4BEG)
  );

endmodule

// File: tb/tb_sw_term_cfg_matrix.sv
// Directed self-checking bench for sw_term_cfg_matrix.
module tb_sw_term_cfg_matrix;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  s1;
  logic [7:0]  s2m, s2e;
  logic [15:0] s4;
  logic [3:0]  n1;
  logic [7:0]  n2, n2b;
  logic [15:0] n4;
  logic        shift, cin, upd, cout;
  logic [15:0] lfsr_m;
  int          checks = 0;
  int          fails  = 0;

  always #5 clk = ~clk;

  sw_term_cfg_matrix #(.N1W(4), .N2W(8), .N4W(16), .LFSR_SEED(16'hACE1)) dut (
    .UserCLK(clk), .UserRST_N(rst_n),
    .S1END(s1), .S2MID(s2m), .S2END(s2e), .S4END(s4),
    .N1BEG(n1), .N2BEG(n2), .N2BEGb(n2b), .N4BEG(n4),
    .cfg_shift(shift), .cfg_in(cin), .cfg_update(upd), .cfg_out(cout)
  );

  // Reference PRBS: 16-bit Fibonacci, taps 16,14,13,11, feedback into bit 0.
  always @(posedge clk) begin
    if (!rst_n) lfsr_m <= 16'hACE1;
    else        lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_byte(input logic [7:0] b, output logic [7:0] seen);
    for (int i = 0; i < 8; i++) begin
      cin     = b[i];
      shift   = 1'b1;
      #1;
      seen[i] = cout;
      tick();
    end
    shift = 1'b0;
    cin   = 1'b0;
  endtask

  task automatic do_update();
    upd = 1'b1;
    tick();
    upd = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s4 = 16'h0001; s1 = 4'b0011; s2m = 8'h01; s2e = 8'h80;
    #1;
    checks++; if (n4 !== 16'h8000) begin fails++; $display("FAIL rst_pre_n4 got %h want 8000", n4); end
    tick();
    checks++; if (n4 !== 16'h8000) begin fails++; $display("FAIL rst_n4 got %h want 8000", n4); end
    checks++; if (n1 !== 4'b1100) begin fails++; $display("FAIL rst_n1 got %b want 1100", n1); end
    checks++; if (n2 !== 8'h80) begin fails++; $display("FAIL rst_n2 got %h want 80", n2); end
    checks++; if (n2b !== 8'h01) begin fails++; $display("FAIL rst_n2b got %h want 01", n2b); end
    checks++; if (cout !== 1'b0) begin fails++; $display("FAIL rst_cfg_out got %b want 0", cout); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reg();
    logic [7:0] seen;
    s4 = 16'h0001;
    shift_byte(8'h40, seen);
    do_update();
    s4 = 16'h00F0;
    #1;
    checks++; if (n4 !== 16'h8000) begin fails++; $display("FAIL reg_nobubble got %h want 8000", n4); end
    checks++; if (n1 !== 4'b1100) begin fails++; $display("FAIL reg_g0_bypass got %b want 1100", n1); end
    tick();
    checks++; if (n4 !== 16'h0F00) begin fails++; $display("FAIL reg_lat1 got %h want 0F00", n4); end
    s4 = 16'h1234;
    #1;
    checks++; if (n4 !== 16'h0F00) begin fails++; $display("FAIL reg_hold got %h want 0F00", n4); end
    tick();
    checks++; if (n4 !== 16'h2C48) begin fails++; $display("FAIL reg_next got %h want 2C48", n4); end
  endtask

  task automatic test_tie_prbs();
    logic [7:0] seen;
    do_reset();
    s1 = 4'b0001; s2m = 8'hFF; s2e = 8'hFF;
    shift_byte(8'hE8, seen);
    do_update();
    checks++; if (n2b !== 8'h00) begin fails++; $display("FAIL tie_n2b got %h want 00", n2b); end
    checks++; if (n2 !== 8'h00) begin fails++; $display("FAIL tie_n2 got %h want 00", n2); end
    checks++; if (n1 !== 4'b1000) begin fails++; $display("FAIL tie_g0_bypass got %b want 1000", n1); end
    for (int c = 0; c < 3; c++) begin
      checks++; if (n4 !== lfsr_m) begin fails++; $display("FAIL prbs_step%0d got %h want %h", c, n4, lfsr_m); end
      tick();
    end
    for (int c = 0; c < 40; c++) begin
      checks++; if (n4 === 16'h0000) begin fails++; $display("FAIL prbs_nonzero got %h want nonzero", n4); end
      tick();
    end
  endtask

  task automatic test_prbs_seed();
    logic [7:0] seen;
    // Seed sequence after reset: ACE1, 59C3, B387 (hand-stepped).
    do_reset();
    checks++; if (lfsr_m !== 16'hACE1) begin fails++; $display("FAIL model_seed got %h want ACE1", lfsr_m); end
    shift_byte(8'hC0, seen);
    do_update();
    checks++; if (n4 !== lfsr_m) begin fails++; $display("FAIL prbs_model got %h want %h", n4, lfsr_m); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seen;
    do_reset();
    s1 = 4'b0001; s2m = 8'h0F; s2e = 8'h01; s4 = 16'h0003;
    shift_byte(8'h55, seen);
    cin = 1'b1; shift = 1'b1; upd = 1'b1;
    tick();
    cin = 1'b0; shift = 1'b0; upd = 1'b0;
    checks++; if (n1 !== 4'b1000) begin fails++; $display("FAIL b2b_n1 got %b want 1000", n1); end
    checks++; if (n2 !== 8'hF0) begin fails++; $display("FAIL b2b_n2 got %h want F0", n2); end
    checks++; if (n2b !== 8'h80) begin fails++; $display("FAIL b2b_n2b got %h want 80", n2b); end
    checks++; if (n4 !== 16'hC000) begin fails++; $display("FAIL b2b_n4 got %h want C000", n4); end
    shift_byte(8'h00, seen);
    checks++; if (seen !== 8'hAA) begin fails++; $display("FAIL b2b_shadow got %h want AA", seen); end
  endtask

  task automatic test_chain();
    logic [7:0] seen;
    do_reset();
    s1 = 4'b0010; s4 = 16'h8000;
    shift_byte(8'hA5, seen);
    shift_byte(8'h3C, seen);
    checks++; if (seen !== 8'hA5) begin fails++; $display("FAIL chain_out got %h want A5", seen); end
    do_update();
    checks++; if (n2 !== lfsr_m[7:0]) begin fails++; $display("FAIL chain_g1_prbs got %h want %h", n2, lfsr_m[7:0]); end
    checks++; if (n2b !== lfsr_m[7:0]) begin fails++; $display("FAIL chain_g2_prbs got %h want %h", n2b, lfsr_m[7:0]); end
    checks++; if (n1 !== 4'b0100) begin fails++; $display("FAIL chain_g0_bypass got %b want 0100", n1); end
    checks++; if (n4 !== 16'h0001) begin fails++; $display("FAIL chain_g3_bypass got %h want 0001", n4); end
  endtask

  task automatic test_reset_midshift();
    logic [7:0] seen;
    s2m = 8'h03; s2e = 8'h10;
    for (int i = 0; i < 3; i++) begin
      cin = 1'b1; shift = 1'b1;
      tick();
    end
    rst_n = 1'b0; upd = 1'b1;
    tick();
    rst_n = 1'b1; upd = 1'b0; shift = 1'b0; cin = 1'b0;
    checks++; if (n2 !== 8'hC0) begin fails++; $display("FAIL mid_n2_bypass got %h want C0", n2); end
    checks++; if (n2b !== 8'h08) begin fails++; $display("FAIL mid_n2b_bypass got %h want 08", n2b); end
    checks++; if (cout !== 1'b0) begin fails++; $display("FAIL mid_cfg_out got %b want 0", cout); end
    shift_byte(8'hFF, seen);
    checks++; if (seen !== 8'h00) begin fails++; $display("FAIL mid_shadow got %h want 00", seen); end
    checks++; if (n2 !== 8'hC0) begin fails++; $display("FAIL mid_hold got %h want C0", n2); end
  endtask

  initial begin
    rst_n = 1'b0; shift = 1'b0; cin = 1'b0; upd = 1'b0;
    s1 = '0; s2m = '0; s2e = '0; s4 = '0;
    test_reset();
    test_reg();
    test_tie_prbs();
    test_prbs_seed();
    test_back_to_back();
    test_chain();
    test_reset_midshift();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
